// File: rtl/bullet_pool_pkg.sv
// Shared geometry constants and bullet types for the projectile pool and its slots.
package bullet_pool_pkg;

  localparam int BULLET_X       = 4;
  localparam int BULLET_Y       = 2;
  localparam int BULLET_STEP_X  = 8;
  localparam int PLAYER_X       = 16;
  localparam int PLAYER_Y       = 32;
  localparam int SQUAT_PLAYER_Y = 16;
  localparam int MAP_X          = 320;

  typedef logic signed [10:0] coord_x_t;
  typedef logic signed [9:0]  coord_y_t;

  typedef struct packed {
    logic     active;
    coord_x_t x;
    coord_y_t y;
  } bullet_t;

  function automatic logic signed [11:0] abs12(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: holds position/live flag and applies move, hit test and map bounds per tick.
module bullet_slot
  import bullet_pool_pkg::*;
#(
  parameter int DIR    = -1,
  parameter int STEP_X = BULLET_STEP_X
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               spawn,
  input  logic signed [10:0] spawn_x,
  input  logic signed [9:0]  spawn_y,
  input  logic signed [10:0] xTarget,
  input  logic signed [9:0]  yTarget,
  input  logic               isSquat,
  output logic               active,
  output logic signed [10:0] x,
  output logic signed [9:0]  y,
  output logic               hit
);

  localparam logic signed [11:0] MOVE        = 12'(DIR * STEP_X);
  localparam logic signed [11:0] HIT_X       = 12'(BULLET_X + PLAYER_X);
  localparam logic signed [11:0] HIT_Y_STAND = 12'(BULLET_Y + PLAYER_Y);
  localparam logic signed [11:0] HIT_Y_SQUAT = 12'(BULLET_Y + SQUAT_PLAYER_Y);
  localparam logic signed [11:0] X_MIN       = 12'(-MAP_X + BULLET_X);
  localparam logic signed [11:0] X_MAX       = 12'(MAP_X - BULLET_X);

  bullet_t slot_q, slot_d;

  logic signed [11:0] x_ext, y_ext, xt_ext, yt_ext, nx, dx, dy, half_h;
  logic               hit_raw, out_raw;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    slot_d  = slot_q;
    x_ext   = {slot_q.x[10], slot_q.x};
    y_ext   = {{2{slot_q.y[9]}}, slot_q.y};
    xt_ext  = {xTarget[10], xTarget};
    yt_ext  = {{2{yTarget[9]}}, yTarget};
    nx      = x_ext + MOVE;
    dx      = abs12(nx - xt_ext);
    dy      = abs12(y_ext - yt_ext);
    half_h  = isSquat ? HIT_Y_SQUAT : HIT_Y_STAND;
    hit_raw = (dx < HIT_X) && (dy < half_h);
    out_raw = (nx < X_MIN) || (nx > X_MAX);
    hit     = tick & slot_q.active & hit_raw;

    // A spawning slot is free, so it is never moved or tested on its spawn tick.
    if (tick) begin
      if (spawn) begin
        slot_d.active = 1'b1;
        slot_d.x      = spawn_x;
        slot_d.y      = spawn_y;
      end else if (slot_q.active) begin
        slot_d.x = nx[10:0];
        if (hit_raw || out_raw) slot_d.active = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so all slots update from the same pre-edge state.
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign active = slot_q.active;
  assign x      = slot_q.x;
  assign y      = slot_q.y;

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot projectile manager: lowest-free-slot spawning with cooldown, registered hit/fire pulses.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int DIR         = -1,
  parameter int STEP_X      = BULLET_STEP_X,
  parameter int COOLDOWN    = 12,
  parameter int SPAWN_DY    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     fire,
  input  logic                     defend,
  input  logic signed [10:0]       xShooter,
  input  logic signed [9:0]        yShooter,
  input  logic signed [10:0]       xTarget,
  input  logic signed [9:0]        yTarget,
  input  logic                     isSquat,
  output logic                     fire_ack,
  output logic [NUM_BULLETS*11-1:0] x,
  output logic [NUM_BULLETS*10-1:0] y,
  output logic [NUM_BULLETS-1:0]   active,
  output logic                     isHit,
  output logic [NUM_BULLETS-1:0]   hit_mask
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] SPAWN_DX = 11'(DIR * (PLAYER_X + BULLET_X));
  localparam logic signed [9:0]  SPAWN_DY_C = 10'(SPAWN_DY);

  logic [NUM_BULLETS-1:0] hit_vec, spawn_vec, lowest_free;
  logic                   any_free, accept;
  logic signed [10:0]     spawn_x;
  logic signed [9:0]      spawn_y;

  logic [CD_W-1:0]        cd_q, cd_d;
  logic                   fire_ack_q, is_hit_q;
  logic [NUM_BULLETS-1:0] hit_mask_q;

  assign spawn_x = xShooter + SPAWN_DX;
  assign spawn_y = yShooter + SPAWN_DY_C;

  // Free slots come from registered state only; a slot retiring this tick is not reusable yet.
  always_comb begin
    lowest_free = '0;
    any_free    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !any_free) begin
        lowest_free[i] = 1'b1;
        any_free       = 1'b1;
      end
    end
    accept    = tick & fire & ~defend & (cd_q == '0) & any_free;
    spawn_vec = accept ? lowest_free : '0;

    cd_d = cd_q;
    if (tick) begin
      if (accept)          cd_d = CD_W'(COOLDOWN);
      else if (cd_q != '0) cd_d = cd_q - CD_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .DIR   (DIR),
      .STEP_X(STEP_X)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .spawn  (spawn_vec[i]),
      .spawn_x(spawn_x),
      .spawn_y(spawn_y),
      .xTarget(xTarget),
      .yTarget(yTarget),
      .isSquat(isSquat),
      .active (active[i]),
      .x      (x[i*11 +: 11]),
      .y      (y[i*10 +: 10]),
      .hit    (hit_vec[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_q       <= '0;
      fire_ack_q <= 1'b0;
      is_hit_q   <= 1'b0;
      hit_mask_q <= '0;
    end else begin
      cd_q       <= cd_d;
      fire_ack_q <= accept;
      is_hit_q   <= |hit_vec;
      hit_mask_q <= hit_vec;
    end
  end

  assign fire_ack = fire_ack_q;
  assign isHit    = is_hit_q;
  assign hit_mask = hit_mask_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: directed scenarios plus random play against a behavioural pool model.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  localparam int NB   = 4;
  localparam int DIR  = -1;
  localparam int STEP = BULLET_STEP_X;
  localparam int CD   = 12;
  localparam int SDY  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, fire = 1'b0, defend = 1'b0, isSquat = 1'b0;
  logic signed [10:0] xShooter = '0, xTarget = '0;
  logic signed [9:0]  yShooter = '0, yTarget = '0;
  logic               fire_ack, isHit;
  logic [NB*11-1:0]   x;
  logic [NB*10-1:0]   y;
  logic [NB-1:0]      active, hit_mask;

  bullet_pool #(
    .NUM_BULLETS(NB), .DIR(DIR), .STEP_X(STEP), .COOLDOWN(CD), .SPAWN_DY(SDY)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire), .defend(defend),
    .xShooter(xShooter), .yShooter(yShooter), .xTarget(xTarget), .yTarget(yTarget),
    .isSquat(isSquat), .fire_ack(fire_ack), .x(x), .y(y), .active(active),
    .isHit(isHit), .hit_mask(hit_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             fire_ack;
    logic [NB-1:0]    hit_mask;
    logic [NB-1:0]    active;
    logic [NB*11-1:0] xs;
    logic [NB*10-1:0] ys;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural model state: plain integers per slot plus a cooldown count.
  bit m_act[NB];
  int m_x[NB];
  int m_y[NB];
  int m_cd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int wrap11(input int v);
    logic signed [10:0] t;
    t = v[10:0];
    return int'(t);
  endfunction

  function automatic int wrap10(input int v);
    logic signed [9:0] t;
    t = v[9:0];
    return int'(t);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 1'b0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_cd = 0;
  endtask

  function automatic exp_t model_state(input logic ack, input logic [NB-1:0] hm);
    exp_t e;
    e.fire_ack = ack;
    e.hit_mask = hm;
    for (int i = 0; i < NB; i++) begin
      e.active[i]        = m_act[i];
      e.xs[i*11 +: 11]   = m_x[i][10:0];
      e.ys[i*10 +: 10]   = m_y[i][9:0];
    end
    return e;
  endfunction

  // Applies one frame tick to the model from the current input values.
  task automatic model_tick(output exp_t e);
    int slot, nx, h;
    bit acc, hit, out;
    logic [NB-1:0] hm;
    slot = -1;
    for (int i = 0; i < NB; i++)
      if (!m_act[i] && slot < 0) slot = i;
    acc = fire && !defend && (m_cd == 0) && (slot >= 0);
    hm  = '0;
    h   = isSquat ? SQUAT_PLAYER_Y : PLAYER_Y;
    for (int i = 0; i < NB; i++) begin
      if (m_act[i]) begin
        nx  = m_x[i] + DIR * STEP;
        hit = (iabs(nx - int'(xTarget)) < BULLET_X + PLAYER_X) &&
              (iabs(m_y[i] - int'(yTarget)) < BULLET_Y + h);
        out = (nx < -MAP_X + BULLET_X) || (nx > MAP_X - BULLET_X);
        m_x[i] = wrap11(nx);
        if (hit) hm[i] = 1'b1;
        if (hit || out) m_act[i] = 1'b0;
      end
    end
    if (acc) begin
      m_act[slot] = 1'b1;
      m_x[slot]   = wrap11(int'(xShooter) + DIR * (PLAYER_X + BULLET_X));
      m_y[slot]   = wrap10(int'(yShooter) + SDY);
    end
    if (acc)           m_cd = CD;
    else if (m_cd > 0) m_cd = m_cd - 1;
    e = model_state(acc, hm);
  endtask

  task automatic do_tick(input bit f, input bit d);
    exp_t e;
    @(negedge clk);
    fire   = f;
    defend = d;
    tick   = 1'b1;
    model_tick(e);
    exp_q.push_back(e);
    @(negedge clk);
    tick   = 1'b0;
    fire   = 1'b0;
    defend = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per tick edge; on other edges the pulses must be quiet.
  logic tick_at_edge = 1'b0;
  always @(posedge clk) tick_at_edge <= tick;

  always @(negedge clk) begin
    if (!rst) begin
      if (tick_at_edge) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("fire_ack", 64'(fire_ack), 64'(e.fire_ack));
          check("hit_mask", 64'(hit_mask), 64'(e.hit_mask));
          check("isHit",    64'(isHit),    64'(|e.hit_mask));
          check("active",   64'(active),   64'(e.active));
          check("x",        64'(x),        64'(e.xs));
          check("y",        64'(y),        64'(e.ys));
        end
      end else begin
        check("idle_pulses", 64'({fire_ack, isHit, hit_mask}), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_active",   64'(active),   64'd0);
    check("rst_x",        64'(x),        64'd0);
    check("rst_y",        64'(y),        64'd0);
    check("rst_pulses",   64'({fire_ack, isHit, hit_mask}), 64'd0);
    rst = 1'b0;

    // Single spawn from x=200, then straight-line flight with no target in the band.
    xShooter = 11'sd200; yShooter = '0; xTarget = '0; yTarget = 10'sd200;
    do_tick(1'b1, 1'b0);
    repeat (3) do_tick(1'b0, 1'b0);

    // Fire on every tick: cooldown spacing, pool filling, drop on same-tick retire.
    apply_reset();
    xShooter = 11'sd300;
    repeat (90) do_tick(1'b1, 1'b0);

    // Y-edge equality never hits; then a real hit standing; then squatting flips it.
    apply_reset();
    xShooter = 11'sd200; yShooter = '0; xTarget = '0; yTarget = 10'sd34; isSquat = 1'b0;
    do_tick(1'b1, 1'b0);
    repeat (70) do_tick(1'b0, 1'b0);
    yTarget = 10'sd20;
    do_tick(1'b1, 1'b0);
    repeat (30) do_tick(1'b0, 1'b0);
    isSquat = 1'b1;
    do_tick(1'b1, 1'b0);
    repeat (70) do_tick(1'b0, 1'b0);
    isSquat = 1'b0;

    // Two co-located bullets hitting on the same tick.
    apply_reset();
    xShooter = 11'sd300; yShooter = '0; xTarget = -11'sd100; yTarget = 10'sd300;
    do_tick(1'b1, 1'b0);
    repeat (12) do_tick(1'b0, 1'b0);
    xShooter = 11'sd196;
    do_tick(1'b1, 1'b0);
    yTarget = '0;
    repeat (40) do_tick(1'b0, 1'b0);

    // Defend blocks fire.
    repeat (3) do_tick(1'b1, 1'b1);
    do_tick(1'b1, 1'b0);

    // Random play.
    for (int n = 0; n < 400; n++) begin
      xShooter = 11'(int'($urandom_range(600)) - 300);
      yShooter = 10'(int'($urandom_range(400)) - 200);
      xTarget  = 11'(int'($urandom_range(600)) - 300);
      yTarget  = 10'(int'(yShooter) + int'($urandom_range(100)) - 50);
      isSquat  = $urandom_range(1) == 1;
      do_tick($urandom_range(1) == 1, $urandom_range(4) == 0);
    end

    // Reset while three bullets fly: immediate kill, cooldown cleared.
    apply_reset();
    isSquat = 1'b0; xShooter = 11'sd300; yShooter = '0; xTarget = '0; yTarget = 10'sd300;
    repeat (30) do_tick(1'b1, 1'b0);
    check("three_in_flight", 64'(active), 64'b0111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_active", 64'(active), 64'd0);
    check("midrst_x",      64'(x),      64'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_tick(1'b1, 1'b0);
    do_tick(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised projectile manager holding NUM_BULLETS independent bullet slots for one shooter (player or enemy).
- Each frame tick it moves every live bullet horizontally, tests it against the opposing character's hitbox (standing or squatting), and retires bullets that hit or leave the map.
- A fire request spawns a bullet in the lowest free slot, gated by a cooldown.
- Sits in GameControl between the character FSMs and the renderer/score logic; it replaces the single-slot bullet.

Parameters:
- NUM_BULLETS, 4, number of slots (1..8).
- DIR, -1, horizontal direction: +1 moves right, -1 moves left.
- STEP_X, BULLET_STEP_X, pixels moved per tick.
- COOLDOWN, 12, ticks after a spawn before the next fire is accepted (0 = no cooldown).
- SPAWN_DY, 0, signed y offset of the spawn point from the shooter centre.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  frame-update strobe, one cycle wide.
- fire  in  1  fire request; sampled only on tick cycles.
- defend  in  1  shooter is defending; blocks fire.
- xShooter  in  11 signed  shooter centre x.
- yShooter  in  10 signed  shooter centre y.
- xTarget  in  11 signed  target centre x.
- yTarget  in  10 signed  target centre y.
- isSquat  in  1  target is squatting; selects SQUAT_PLAYER_Y as hitbox half-height instead of PLAYER_Y.
- fire_ack  out  1  one-cycle pulse when a bullet spawned.
- x  out  NUM_BULLETS x 11 signed  per-slot bullet x.
- y  out  NUM_BULLETS x 10 signed  per-slot bullet y.
- active  out  NUM_BULLETS  per-slot live flag.
- isHit  out  1  one-cycle pulse when any bullet hit on this tick.
- hit_mask  out  NUM_BULLETS  slots that hit on this tick, valid with isHit.

Behaviour:
- Reset (async, rst=1):
  - active=0, x=0, y=0.
  - Cooldown counter = 0.
  - fire_ack, isHit, hit_mask all 0.
  - A reset mid-flight kills all bullets immediately.
- Non-tick cycles: all state holds; fire_ack, isHit and hit_mask are 0.
- On a tick cycle, all slots are updated in parallel from the registered state.
  - Move: nx = x + DIR*STEP_X. Compute in 12-bit signed, then truncate to 11 bits for storage.
  - Hit test on the moved position: |nx - xTarget| < BULLET_X + PLAYER_X AND |y - yTarget| < BULLET_Y + H, where H = isSquat ? SQUAT_PLAYER_Y : PLAYER_Y. Compute in 12-bit signed; strict inequalities (touching edges do not count as a hit).
  - Bounds: nx < -MAP_X + BULLET_X or nx > MAP_X - BULLET_X means out of map.
  - A slot that hits sets its hit_mask bit and clears active. If hit and out-of-bounds occur together, it is still a hit.
  - An out-of-map slot clears active with no hit.
  - Retired slots keep their last x/y.
- Fire, evaluated in the same tick cycle:
  - Accepted iff fire & ~defend & cooldown==0 & at least one slot that is free in the registered state.
  - A slot freed by this tick's hit/exit is not reusable until the next tick.
  - On accept, the lowest-index free slot gets active=1, x = xShooter + DIR*(PLAYER_X+BULLET_X), y = yShooter + SPAWN_DY.
  - The new bullet is neither moved nor hit-tested on its spawn tick.
  - On accept: fire_ack=1 and cooldown loads COOLDOWN.
- Cooldown decrements by 1 on each tick while nonzero; it is not decremented on the spawn tick itself.
- Pool full or cooldown nonzero: the request is dropped (fire_ack=0). No queueing.
- Output timing:
  - isHit = |hit_mask.
  - isHit and hit_mask are registered; they assert in the cycle after the tick and last exactly one cycle.
  - fire_ack is registered the same way.
  - x/y/active update in the cycle after the tick.
- Multiple slots hitting on one tick: one isHit pulse, with several hit_mask bits set. Score logic counts the bits.
- Cooldown counter width = $clog2(COOLDOWN+1), minimum 1 bit.

Decomposition:
- GamePkg holds the geometry constants: BULLET_X, BULLET_Y, BULLET_STEP_X, PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, MAP_X.
- New typedefs in GamePkg: coord_x_t (logic signed [10:0]), coord_y_t (logic signed [9:0]) and bullet_t {active, x, y}.
- One sub-module: bullet_slot. It holds one slot's registers and contains the move, hit and bounds logic, with inputs tick, spawn, spawn_x, spawn_y and target/isSquat.
- bullet_pool instantiates NUM_BULLETS slots and adds the priority free-slot encoder, the cooldown counter and the output registers.

Test Plan:
- Reset, then fire on a tick with xShooter=200, yShooter=0, DIR=-1 → fire_ack pulse; slot0 active at x = 200 - PLAYER_X - BULLET_X, y=0; after the next tick, x drops by STEP_X.
- Fire on every tick with COOLDOWN=12 → spawns on ticks 0, 13, 26 only; with NUM_BULLETS=2 and no retirement, the third accepted request is dropped.
- Bullet reaches the target with yTarget=yShooter, isSquat=0 → on the first overlapping tick isHit pulses once, hit_mask=0001, slot0 inactive. Repeat with the overlap at exactly the edge (equality) → no hit.
- Target squatting, with bullet y between SQUAT_PLAYER_Y and PLAYER_Y band edges → hit only when the band condition holds for H=SQUAT_PLAYER_Y; toggling isSquat between runs flips the outcome.
- Two bullets hitting on the same tick → a single isHit pulse with hit_mask=0011; fire plus defend=1 → no spawn; fire while a slot frees on the same tick with the pool full → dropped.
- Assert rst while 3 bullets are in flight, mid-tick → all active=0 immediately; cooldown=0, so the first fire after release is accepted.
